// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SPI serial-clock burst generator.
// Produces nbits SCK pulses per burst, with each phase (setup, active,
// inactive) lasting div+1 clk cycles. It also produces one-cycle
// edge/strobe pulses for a companion shift register.
//
// Ports
//   clk         in   clock, all logic on rising edge
//   rst         in   synchronous active-high reset
//   start       in   request a burst (honoured only when idle)
//   div         in   half-period minus one, sampled with start
//   nbits       in   SCK pulses per burst, sampled with start
//   abort       in   terminate the burst immediately
//   sck         out  serial clock (idles at CPOL)
//   busy        out  burst in progress
//   done        out  one-cycle pulse after the final inactive phase
//   lead_edge   out  first cycle of each active phase
//   trail_edge  out  first cycle of each inactive phase
//   sample_stb  out  sample strobe (lead for CPHA=0, trail for CPHA=1)
//   shift_stb   out  shift strobe  (trail for CPHA=0, lead for CPHA=1)
module spi_sck_gen #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned NBITS_W = 5,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   div,
    input  logic [NBITS_W-1:0] nbits,
    input  logic               abort,
    output logic               sck,
    output logic               busy,
    output logic               done,
    output logic               lead_edge,
    output logic               trail_edge,
    output logic               sample_stb,
    output logic               shift_stb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ACT   = 2'd2,
        INACT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [NBITS_W-1:0] rem_q, rem_d;

    logic sck_d, busy_d, done_d, lead_d, trail_d, sample_d, shift_d;
    logic phase_end;
    logic accept;

    // A phase ends when the counter reaches the latched divider; the counter
    // clears on every state change, so it never wraps even at the maximum div.
    assign phase_end = (phase_q == div_q);
    // Abort beats start while idle.
    assign accept    = (state_q == IDLE) && start && !abort;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && (nbits != '0)) state_d = SETUP;
            SETUP:   if (phase_end) state_d = ACT;
            ACT:     if (phase_end) state_d = INACT;
            INACT:   if (phase_end) state_d = (rem_q == '0) ? IDLE : ACT;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Phase, divider and remaining-pulse counters
    always_comb begin
        phase_d = phase_q + CNT_W'(1);
        div_d   = div_q;
        rem_d   = rem_q;
        if ((state_q == IDLE) || (state_d != state_q)) begin
            phase_d = '0;
        end
        if ((state_q == IDLE) && (state_d == SETUP)) begin
            div_d = div;
            rem_d = nbits;
        end
        // Decrementing on ACT->INACT leaves rem_q at zero during the last INACT.
        if ((state_q == ACT) && (state_d == INACT)) begin
            rem_d = rem_q - NBITS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            div_q   <= '0;
            rem_q   <= '0;
        end else begin
            phase_q <= phase_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
        end
    end

    // Output logic: computed from the upcoming state so registered outputs
    // line up with the state they describe.
    always_comb begin
        sck_d    = (state_d == ACT) ? ~CPOL : CPOL;
        busy_d   = (state_d != IDLE);
        lead_d   = (state_d == ACT) && (state_q != ACT);
        trail_d  = (state_d == INACT) && (state_q != INACT);
        done_d   = !abort && (((state_q == INACT) && (state_d == IDLE)) ||
                              (accept && (nbits == '0)));
        sample_d = CPHA ? trail_d : lead_d;
        shift_d  = CPHA ? lead_d : trail_d;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sck        <= CPOL;
            busy       <= 1'b0;
            done       <= 1'b0;
            lead_edge  <= 1'b0;
            trail_edge <= 1'b0;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
        end else begin
            sck        <= sck_d;
            busy       <= busy_d;
            done       <= done_d;
            lead_edge  <= lead_d;
            trail_edge <= trail_d;
            sample_stb <= sample_d;
            shift_stb  <= shift_d;
        end
    end

endmodule

// File: tb/tb_spi_sck_gen.sv
// Testbench for spi_sck_gen. Two instances (CPOL=0/CPHA=0 and CPOL=1/CPHA=1)
// share stimulus. Expected per-cycle output vectors are derived from burst
// timing formulas, queued when a burst is launched, and popped each cycle.
module tb_spi_sck_gen;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned NBITS_W = 5;

    logic               clk = 1'b0;
    logic               rst, start, abort;
    logic [CNT_W-1:0]   div;
    logic [NBITS_W-1:0] nbits;

    logic sck_a, busy_a, done_a, lead_a, trail_a, samp_a, shift_a;
    logic sck_b, busy_b, done_b, lead_b, trail_b, samp_b, shift_b;
    logic [6:0] obs_a, obs_b;

    logic [13:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    spi_sck_gen #(.CNT_W(CNT_W), .NBITS_W(NBITS_W), .CPOL(1'b0), .CPHA(1'b0)) u_a (
        .clk(clk), .rst(rst), .start(start), .div(div), .nbits(nbits), .abort(abort),
        .sck(sck_a), .busy(busy_a), .done(done_a), .lead_edge(lead_a),
        .trail_edge(trail_a), .sample_stb(samp_a), .shift_stb(shift_a)
    );

    spi_sck_gen #(.CNT_W(CNT_W), .NBITS_W(NBITS_W), .CPOL(1'b1), .CPHA(1'b1)) u_b (
        .clk(clk), .rst(rst), .start(start), .div(div), .nbits(nbits), .abort(abort),
        .sck(sck_b), .busy(busy_b), .done(done_b), .lead_edge(lead_b),
        .trail_edge(trail_b), .sample_stb(samp_b), .shift_stb(shift_b)
    );

    // Vector order: {sck, busy, done, lead, trail, sample, shift}
    assign obs_a = {sck_a, busy_a, done_a, lead_a, trail_a, samp_a, shift_a};
    assign obs_b = {sck_b, busy_b, done_b, lead_b, trail_b, samp_b, shift_b};

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] expv);
        n_checks++;
        if (got === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got a=%b b=%b, expected a=%b b=%b",
                     tag, got[13:7], got[6:0], expv[13:7], expv[6:0]);
        end
    endtask

    // Expected outputs in cycle k after a start (k=1 is the first cycle after
    // the start edge). cut>0 means abort/reset was applied in cycle cut.
    function automatic logic [6:0] exp_vec(input int k, input int d, input int n,
                                           input int cut, input bit cpol, input bit cpha);
        int   p, total, idx, off;
        logic act, inact, lead, trail;
        p     = d + 1;
        total = (n == 0) ? 0 : (2 * n + 1) * p;
        if (cut > 0 && k > cut) return {cpol, 6'b0};
        if (k <= total) begin
            idx   = (k - 1) / p;
            off   = (k - 1) % p;
            act   = (idx % 2) == 1;
            inact = (idx > 0) && ((idx % 2) == 0);
            lead  = act && (off == 0);
            trail = inact && (off == 0);
            return {act ? ~cpol : cpol, 1'b1, 1'b0, lead, trail,
                    cpha ? trail : lead, cpha ? lead : trail};
        end
        if (k == total + 1) return {cpol, 1'b0, 1'b1, 4'b0};
        return {cpol, 6'b0};
    endfunction

    // Launch one burst and check every cycle until done (or past the cut).
    task automatic run(input int d, input int n, input int cut, input bit cut_rst,
                       input bit hold, input bit scramble, input string tag);
        int total, len;
        total = (n == 0) ? 0 : (2 * n + 1) * (d + 1);
        len   = (cut > 0) ? cut + 2 : total + 1;
        for (int k = 1; k <= len; k++) begin
            exp_q.push_back({exp_vec(k, d, n, cut, 1'b0, 1'b0),
                             exp_vec(k, d, n, cut, 1'b1, 1'b1)});
        end
        start = 1'b1;
        div   = CNT_W'(d);
        nbits = NBITS_W'(n);
        abort = 1'b0;
        rst   = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s k=%0d", tag, k), {obs_a, obs_b}, exp_q.pop_front());
            start = hold;
            abort = 1'b0;
            rst   = 1'b0;
            if (scramble && k < total) begin
                start = 1'($urandom);
                div   = CNT_W'($urandom);
                nbits = NBITS_W'($urandom);
            end
            if (k == cut) begin
                if (cut_rst) rst = 1'b1;
                else         abort = 1'b1;
            end
        end
    endtask

    // Hold the given idle-state inputs and expect idle outputs.
    task automatic idle_chk(input int ncyc, input bit st, input bit ab, input bit rs,
                            input string tag);
        start = st;
        abort = ab;
        rst   = rs;
        nbits = NBITS_W'(3);
        div   = CNT_W'(1);
        for (int k = 1; k <= ncyc; k++) begin
            exp_q.push_back({1'b0, 6'b0, 1'b1, 6'b0});
            @(posedge clk);
            #1;
            check($sformatf("%s k=%0d", tag, k), {obs_a, obs_b}, exp_q.pop_front());
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        div   = '0;
        nbits = '0;
        #1;
        // Reset holds off a simultaneous start.
        idle_chk(3, 1'b1, 1'b0, 1'b1, "reset");
        idle_chk(2, 1'b0, 1'b0, 1'b0, "post_reset");

        run(1, 2, 0, 1'b0, 1'b0, 1'b0, "basic");
        idle_chk(1, 1'b0, 1'b0, 1'b0, "basic_idle");

        run(0, 16, 0, 1'b0, 1'b0, 1'b0, "n16");
        idle_chk(1, 1'b0, 1'b0, 1'b0, "n16_idle");

        run(2, 0, 0, 1'b0, 1'b0, 1'b0, "zero_len");
        idle_chk(2, 1'b0, 1'b0, 1'b0, "zero_idle");

        run(1, 2, 0, 1'b0, 1'b1, 1'b0, "b2b_first");
        run(0, 3, 0, 1'b0, 1'b0, 1'b0, "b2b_second");
        idle_chk(2, 1'b0, 1'b0, 1'b0, "b2b_idle");

        run(3, 4, 14, 1'b0, 1'b0, 1'b0, "abort");
        idle_chk(2, 1'b0, 1'b0, 1'b0, "abort_idle");

        run(1, 3, 5, 1'b1, 1'b0, 1'b0, "mid_rst");
        run(2, 1, 0, 1'b0, 1'b0, 1'b0, "after_rst");
        idle_chk(1, 1'b0, 1'b0, 1'b0, "after_rst_idle");

        run(2, 3, 0, 1'b0, 1'b0, 1'b1, "ignored");
        idle_chk(3, 1'b0, 1'b0, 1'b0, "ignored_idle");

        idle_chk(3, 1'b1, 1'b1, 1'b0, "abort_start_idle");
        idle_chk(2, 1'b0, 1'b1, 1'b0, "abort_idle_only");

        run(255, 1, 0, 1'b0, 1'b0, 1'b0, "div_max");
        run(0, 31, 0, 1'b0, 1'b0, 1'b0, "nbits_max");
        idle_chk(2, 1'b0, 1'b0, 1'b0, "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_sck_gen.md
SPI_SCK_GEN -- requirements
Module: spi_sck_gen

Interface
REQ-001 Parameter CNT_W, default 8: width of the half-period divider input and counter.
REQ-002 Parameter NBITS_W, default 5: width of the pulse-count input (MAX7219 frame = 16).
REQ-003 Parameter CPOL, default 0: SCK idle level.
REQ-004 Parameter CPHA, default 0: 0 = sample on leading edge and shift on trailing edge; 1 = the reverse.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request one burst; honoured only when busy=0.
REQ-008 div  in  CNT_W  half-period minus one, in clk cycles; sampled with start.
REQ-009 nbits  in  NBITS_W  SCK pulses per burst; sampled with start.
REQ-010 abort  in  1  terminate the burst immediately.
REQ-011 sck  out  1  serial clock, registered.
REQ-012 busy  out  1  burst in progress, registered.
REQ-013 done  out  1  one-cycle pulse at burst completion, registered.
REQ-014 lead_edge, trail_edge  out  1 each  one-cycle pulses, registered.
REQ-015 sample_stb, shift_stb  out  1 each  one-cycle pulses, registered.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACT and INACT.
REQ-017 IDLE: start=1 and nbits!=0 SHALL latch div and nbits, load the phase counter and the remaining-pulse counter, and enter SETUP with busy=1 from the next cycle.
REQ-018 start=1 with nbits=0 SHALL leave the FSM in IDLE, keep busy=0 and pulse done in the next cycle.
REQ-019 SETUP, ACT and INACT SHALL each last exactly div+1 cycles, timed by a phase counter that counts up and clears on every state change.
REQ-020 Transitions: SETUP->ACT; ACT->INACT; INACT->ACT while pulses remain; INACT->IDLE after the last pulse.
REQ-021 sck SHALL be CPOL in IDLE, SETUP and INACT, and !CPOL in ACT.
REQ-022 lead_edge SHALL be 1 only in the first cycle of each ACT; trail_edge SHALL be 1 only in the first cycle of each INACT.
REQ-023 With CPHA=0: sample_stb = lead_edge and shift_stb = trail_edge.
REQ-024 With CPHA=1: sample_stb = trail_edge and shift_stb = lead_edge.
REQ-025 The remaining-pulse counter SHALL decrement on each ACT->INACT transition.
REQ-026 done SHALL pulse for exactly one cycle, in the cycle after the final INACT cycle, with busy=0 in that same cycle.
REQ-027 A start in the cycle in which done=1 SHALL be accepted.
REQ-028 Burst length in busy cycles SHALL be (2*nbits+1)*(div+1).
REQ-029 start while busy=1 SHALL be ignored; changes to div or nbits while busy SHALL NOT affect the burst in progress.
REQ-030 div=0 SHALL give sck toggling every cycle (sck = clk/2).
REQ-031 div=2^CNT_W-1 SHALL give 2^CNT_W cycles per phase with no counter overflow.
REQ-032 nbits=2^NBITS_W-1 SHALL produce exactly that many pulses.
REQ-033 abort=1 in any busy state SHALL, in the next cycle, force IDLE, sck=CPOL and busy=0, with no done and no edge or strobe pulses.
REQ-034 abort=1 in IDLE SHALL have no effect.
REQ-035 abort=1 together with start=1 in IDLE SHALL give priority to abort, so no burst starts.

Reset
REQ-036 rst=1 SHALL, at the next clock edge, force IDLE, sck=CPOL, busy=0, done=0, all edge and strobe outputs 0, and all counters 0.
REQ-037 rst SHALL take priority over start and abort, including when asserted mid-burst.
REQ-038 After rst deasserts, the first start SHALL behave as in REQ-017.

Verification
REQ-039 Basic burst: CPOL=0, CPHA=0, div=1, nbits=2, start at cycle 0 -> sck high in cycles 3-4 and 7-8, low otherwise; busy in cycles 1-10; lead_edge/sample_stb at 3 and 7; trail_edge/shift_stb at 5 and 9; done at 11.
REQ-040 CPOL=1, CPHA=1, div=0, nbits=16 -> sck low in ACT and idles high; shift_stb on each lead_edge, sample_stb on each trail_edge; 16 pulses; busy for 33 cycles; done once.
REQ-041 Zero-length and back-to-back: nbits=0 -> done the cycle after start, busy never 1; start held high through done -> second burst begins the cycle after done with no gap.
REQ-042 Abort: div=3, nbits=4, abort in the 2nd ACT -> next cycle sck=CPOL, busy=0; no done; no further strobes.
REQ-043 Reset mid-burst: rst for 1 cycle during INACT -> all outputs at reset values next cycle; a new start with div=2, nbits=1 gives busy for 9 cycles.
REQ-044 Ignored inputs: start, div and nbits changed while busy -> burst timing matches the originally latched values; exactly one done.
